// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I multicycle front end that owns the PC and fetches instruction words.
// Ports:
//   clk, reset               core clock, synchronous active-high reset
//   fetch_req                control FSM pulse: fetch the word at pc
//   pc_load, pc_target       redirect request and its byte address
//   mem_addr, mem_rd_en      instruction memory address and read strobe (strobe in REQ only)
//   mem_rdata, mem_rvalid    instruction memory read data and its valid flag
//   instr, instr_pc          held instruction word and the PC it was fetched from
//   pc                       next fetch address
//   instr_valid              one-cycle pulse after each capture
//   busy                     high while a fetch is in flight (REQ or WAIT)
//   fetch_err                sticky flag for misaligned redirect targets
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic        pc_load,
    input  logic [31:0] pc_target,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc,
    output logic        instr_valid,
    output logic        busy,
    output logic        fetch_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, instr_pc_q, instr_pc_d, pend_tgt_q, pend_tgt_d;
    logic        instr_valid_q, instr_valid_d, fetch_err_q, fetch_err_d, pend_q, pend_d;
    logic        cap, load_ok, load_bad;
    assign busy      = state_q != IDLE;
    assign cap       = busy && mem_rvalid;
    assign load_ok   = pc_load && pc_target[1:0] == 2'b00;
    assign load_bad  = pc_load && pc_target[1:0] != 2'b00;
    assign mem_addr  = pc_q;
    assign mem_rd_en = state_q == REQ;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc          = pc_q;
    assign instr_valid = instr_valid_q;
    assign fetch_err   = fetch_err_q;
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        pend_d        = pend_q;
        pend_tgt_d    = pend_tgt_q;
        instr_valid_d = cap;
        fetch_err_d   = fetch_err_q | load_bad;
        if (!busy) begin
            // any pc_load, even a rejected one, swallows a simultaneous fetch_req
            if (load_ok) pc_d = pc_target;
            else if (fetch_req && !pc_load) state_d = REQ;
        end else if (cap) begin
            state_d    = IDLE;
            instr_d    = mem_rdata;
            instr_pc_d = pc_q;
            // a redirect arriving in the capture cycle itself beats an older pending one
            pc_d       = load_ok ? pc_target : pend_q ? pend_tgt_q : pc_q + 32'd4;
            pend_d     = 1'b0;
        end else begin
            state_d = WAIT;
            if (load_ok) begin
                pend_d     = 1'b1;
                pend_tgt_d = pc_target;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            pend_q        <= 1'b0;
            pend_tgt_q    <= RESET_PC;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
            pend_q        <= pend_d;
            pend_tgt_q    <= pend_tgt_d;
        end
    end
endmodule
